// File: rtl/pulse_period_meter.sv
// Measures an asynchronous square wave in clock cycles: rise-to-rise period and high time,
// with a one-cycle valid strobe per completed period plus lock and timeout status.
module pulse_period_meter #(
  parameter int CNT_WIDTH      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 54_000_000
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_sig,
  input  logic                 in_clr,
  output logic [CNT_WIDTH-1:0] out_period,
  output logic [CNT_WIDTH-1:0] out_high,
  output logic                 out_valid,
  output logic                 out_locked,
  output logic                 out_timeout
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_period_meter: SYNC_STAGES must be at least 2");
  end
  if ((TIMEOUT_CYCLES < 1) ||
      (64'(TIMEOUT_CYCLES) >= ((64'd1 << CNT_WIDTH) - 64'd1))) begin : g_bad_timeout
    $error("pulse_period_meter: TIMEOUT_CYCLES must be in 1 .. 2**CNT_WIDTH-2");
  end

  localparam logic [CNT_WIDTH-1:0] TMO  = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO = CNT_WIDTH'(0);

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_ARMED    = 2'd1,
    ST_MEASURE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_per_cnt;
  logic [CNT_WIDTH-1:0]   r_hi_cnt;
  logic [CNT_WIDTH-1:0]   r_period;
  logic [CNT_WIDTH-1:0]   r_high;
  logic                   r_valid;
  logic                   r_locked;
  logic                   r_timeout;

  logic w_s;
  logic w_rise;
  logic w_primed;

  // r_fill marks when the last sync stage holds a real sample rather than its reset
  // value, so an input held high through reset cannot look like a low-then-rise.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_sync <= '0;
      r_fill <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_sig};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_s;
    end
  end

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_s & ~r_prev;
  assign w_primed = r_fill[SYNC_STAGES-1];

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state   <= ST_WAIT_LOW;
      r_per_cnt <= ZERO;
      r_hi_cnt  <= ZERO;
      r_period  <= ZERO;
      r_high    <= ZERO;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (in_clr) begin
        r_state   <= ST_WAIT_LOW;
        r_per_cnt <= ZERO;
        r_hi_cnt  <= ZERO;
        r_period  <= ZERO;
        r_high    <= ZERO;
        r_locked  <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          ST_WAIT_LOW: begin
            if (w_primed && !w_s) begin
              r_state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (w_rise) begin
              r_state   <= ST_MEASURE;
              r_per_cnt <= ONE;
              r_hi_cnt  <= ONE;
              r_timeout <= 1'b0;
            end
          end
          ST_MEASURE: begin
            // A rise on the timeout cycle still closes a valid period of TIMEOUT_CYCLES.
            if (w_rise) begin
              r_period  <= r_per_cnt;
              r_high    <= r_hi_cnt;
              r_valid   <= 1'b1;
              r_locked  <= 1'b1;
              r_timeout <= 1'b0;
              r_per_cnt <= ONE;
              r_hi_cnt  <= ONE;
            end else if (r_per_cnt == TMO) begin
              r_state   <= ST_WAIT_LOW;
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_period  <= ZERO;
              r_high    <= ZERO;
              r_per_cnt <= ZERO;
              r_hi_cnt  <= ZERO;
            end else begin
              r_per_cnt <= r_per_cnt + ONE;
              if (w_s) begin
                r_hi_cnt <= r_hi_cnt + ONE;
              end
            end
          end
          default: begin
            r_state <= ST_WAIT_LOW;
          end
        endcase
      end
    end
  end

  assign out_period  = r_period;
  assign out_high    = r_high;
  assign out_valid   = r_valid;
  assign out_locked  = r_locked;
  assign out_timeout = r_timeout;

endmodule
